// File: rtl/ring_osc_freq_meter.sv
// Purpose: counts synchronised oscillator rising edges over a gate window of clk cycles.
// Latency: osc_in to edge strobe is SYNC_STAGES+1 cycles; valid pulses the cycle after the last window cycle.
// Backpressure: none; each result is a single-cycle valid pulse that the reader must capture.
module ring_osc_freq_meter #(
   parameter int CNT_W       = 15,
   parameter int GATE_W      = 16,
   parameter int SYNC_STAGES = 2   // must be 2 or more
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              osc_in,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              result_ovf,
   output logic              valid
);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0]  ACC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                hist_q;
   logic                rise;
   logic [GATE_W-1:0]   win_q, win_nxt;
   logic [GATE_W-1:0]   gate_eff;
   logic [CNT_W-1:0]    acc_q, acc_nxt, acc_upd;
   logic                ovf_acc_q, ovf_acc_nxt, ovf_upd;
   logic [CNT_W-1:0]    result_q, result_nxt;
   logic                result_ovf_q, result_ovf_nxt;
   logic                valid_q, valid_nxt;

   // Synchroniser plus history flop; runs in every state so no flush is needed between windows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

   // A zero gate length is treated as a one-cycle window.
   assign gate_eff = (gate_len == '0) ? GATE_ONE : gate_len;

   // Accumulator value including this cycle's edge, holding at all-ones and flagging overflow.
   always_comb begin
      acc_upd = acc_q;
      ovf_upd = ovf_acc_q;
      if (rise) begin
         if (&acc_q) begin
            ovf_upd = 1'b1;
         end else begin
            acc_upd = acc_q + ACC_ONE;
         end
      end
   end

   // Next-state and datapath decisions; abort outranks window end.
   always_comb begin
      state_nxt      = state_q;
      win_nxt        = win_q;
      acc_nxt        = acc_q;
      ovf_acc_nxt    = ovf_acc_q;
      result_nxt     = result_q;
      result_ovf_nxt = result_ovf_q;
      valid_nxt      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_nxt   = MEASURE;
               win_nxt     = gate_eff;
               acc_nxt     = '0;
               ovf_acc_nxt = 1'b0;
            end
         end
         MEASURE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (win_q == GATE_ONE) begin
               result_nxt     = acc_upd;
               result_ovf_nxt = ovf_upd;
               valid_nxt      = 1'b1;
               if (continuous) begin
                  // Back-to-back window: reload without a gap cycle.
                  win_nxt     = gate_eff;
                  acc_nxt     = '0;
                  ovf_acc_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               win_nxt     = win_q - GATE_ONE;
               acc_nxt     = acc_upd;
               ovf_acc_nxt = ovf_upd;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Window counter, accumulator and published result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q        <= '0;
         acc_q        <= '0;
         ovf_acc_q    <= 1'b0;
         result_q     <= '0;
         result_ovf_q <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         win_q        <= win_nxt;
         acc_q        <= acc_nxt;
         ovf_acc_q    <= ovf_acc_nxt;
         result_q     <= result_nxt;
         result_ovf_q <= result_ovf_nxt;
         valid_q      <= valid_nxt;
      end
   end

   assign busy       = (state_q == MEASURE);
   assign result     = result_q;
   assign result_ovf = result_ovf_q;
   assign valid      = valid_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
module tb_ring_osc_freq_meter;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        osc_in = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] gate_len = 16'd0;

   logic        busy, valid, result_ovf;
   logic [14:0] result;
   logic        busy4, valid4, ovf4;
   logic [3:0]  result4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ring_osc_freq_meter #(.CNT_W(15), .GATE_W(16), .SYNC_STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start),
      .continuous(continuous), .abort(abort), .gate_len(gate_len),
      .busy(busy), .result(result), .result_ovf(result_ovf), .valid(valid)
   );

   ring_osc_freq_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(S)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start),
      .continuous(continuous), .abort(abort), .gate_len(gate_len),
      .busy(busy4), .result(result4), .result_ovf(ovf4), .valid(valid4)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- oscillator driver (bench-synchronous) ----------------
   int osc_half = 0;   // 0 = hold osc_hold, else toggle every osc_half cycles
   bit osc_hold = 1'b0;
   bit osc_rand = 1'b0;
   int osc_ph   = 0;

   always @(negedge clk) begin
      if (osc_rand) begin
         osc_in = 1'($urandom_range(0, 1));
      end else if (osc_half == 0) begin
         osc_in = osc_hold;
      end else begin
         osc_ph++;
         if (osc_ph >= osc_half) begin
            osc_ph = 0;
            osc_in = ~osc_in;
         end
      end
   end

   // ---------------- behavioural model ----------------
   // Every sampled osc value is recorded per clock edge; an edge counted at clock n
   // is a 0->1 step between the values sampled S+1 and S clocks earlier. Counts are
   // kept unbounded and clipped to each DUT's width only at comparison time.
   bit oscv [0:65535];
   int cyc       = 0;
   int first_idx = 1;
   bit m_busy    = 1'b0;
   bit m_valid   = 1'b0;
   bit m_rise;
   int m_left    = 0;
   int m_cnt     = 0;
   int m_res     = 0;

   function automatic bit oval(input int i);
      if (i < first_idx) return 1'b0;
      return oscv[i];
   endfunction

   function automatic int eff(input logic [15:0] g);
      return (g == 16'd0) ? 1 : int'(g);
   endfunction

   function automatic int clip(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy    = 1'b0;
         m_valid   = 1'b0;
         m_left    = 0;
         m_cnt     = 0;
         m_res     = 0;
         first_idx = cyc + 1;
      end else begin
         cyc++;
         oscv[cyc] = osc_in;
         m_rise    = oval(cyc - S) & ~oval(cyc - S - 1);
         m_valid   = 1'b0;
         if (!m_busy) begin
            if (start && !abort) begin
               m_busy = 1'b1;
               m_left = eff(gate_len);
               m_cnt  = 0;
            end
         end else if (abort) begin
            m_busy = 1'b0;
         end else begin
            m_cnt  = m_cnt + int'(m_rise);
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_res   = m_cnt;
               m_valid = 1'b1;
               if (continuous) begin
                  m_left = eff(gate_len);
                  m_cnt  = 0;
               end else begin
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   // Per-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      chk("busy",    int'(busy),       int'(m_busy));
      chk("valid",   int'(valid),      int'(m_valid));
      chk("result",  int'(result),     clip(m_res, 32767));
      chk("ovf",     int'(result_ovf), int'(m_res > 32767));
      chk("busy4",   int'(busy4),      int'(m_busy));
      chk("valid4",  int'(valid4),     int'(m_valid));
      chk("result4", int'(result4),    clip(m_res, 15));
      chk("ovf4",    int'(ovf4),       int'(m_res > 15));
   end

   // ---------------- directed helpers ----------------
   task automatic wait_valid(output int n, input int lim);
      n = 1;
      while (!valid && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("valid_seen", int'(valid), 1);
   endtask

   // Pulses start for one cycle; n counts negedges from the start-sampling edge to valid.
   task automatic run_single(input int g, output int n);
      gate_len = 16'(g);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_valid(n, g + 20);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int vcnt;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_ovf",    int'(result_ovf), 0);
      chk("rst_valid",  int'(valid), 0);
      rst_n = 1'b1;

      // Period 4, gate 100, single shot
      osc_half = 2;
      repeat (10) @(negedge clk);
      run_single(100, n);
      chk("t1_latency", n, 101);
      chk("t1_result",  int'(result), 25);
      chk("t1_ovf",     int'(result_ovf), 0);
      chk("t1_busy_at_valid", int'(busy), 0);
      @(negedge clk);
      chk("t1_valid_once", int'(valid), 0);
      chk("t1_busy_after", int'(busy), 0);

      // Period 2, gate 64: narrow counter saturates
      osc_half = 1;
      repeat (8) @(negedge clk);
      run_single(64, n);
      chk("t2_latency", n, 65);
      chk("t2_result4", int'(result4), 15);
      chk("t2_ovf4",    int'(ovf4), 1);
      chk("t2_result",  int'(result), 32);
      chk("t2_ovf",     int'(result_ovf), 0);

      // Continuous, gate 40, period 8
      osc_half = 4;
      repeat (10) @(negedge clk);
      continuous = 1'b1;
      run_single(40, n);
      chk("t3_first_latency", n, 41);
      chk("t3_result0", int'(result), 5);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         wait_valid(n, 60);
         chk("t3_spacing", n, 40);
         chk("t3_result",  int'(result), 5);
         chk("t3_busy_cont", int'(busy), 1);
      end
      continuous = 1'b0;
      @(negedge clk);
      wait_valid(n, 60);
      chk("t3_last_spacing", n, 40);
      chk("t3_last_result",  int'(result), 5);
      chk("t3_last_busy",    int'(busy), 0);
      @(negedge clk);
      chk("t3_idle_busy", int'(busy), 0);

      // gate 0 and gate 1 with osc held high: identical one-cycle windows
      osc_half = 0;
      osc_hold = 1'b1;
      repeat (10) @(negedge clk);
      run_single(0, n);
      chk("t4_g0_latency", n, 2);
      chk("t4_g0_result",  int'(result), 0);
      @(negedge clk);
      chk("t4_g0_valid_once", int'(valid), 0);
      run_single(1, n);
      chk("t4_g1_latency", n, 2);
      chk("t4_g1_result",  int'(result), 0);
      @(negedge clk);
      chk("t4_g1_valid_once", int'(valid), 0);

      // Abort 30 cycles into a window after a result of 25
      osc_half = 2;
      repeat (10) @(negedge clk);
      run_single(100, n);
      chk("t5_pre_result", int'(result), 25);
      @(negedge clk);
      gate_len = 16'd100;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      repeat (29) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_busy_after_abort", int'(busy), 0);
      vcnt = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (valid) vcnt++;
      end
      chk("t5_no_valid", vcnt, 0);
      chk("t5_result_held", int'(result), 25);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("t5_start_abort_busy", int'(busy), 0);
      @(negedge clk);
      chk("t5_start_abort_busy2", int'(busy), 0);

      // Asynchronous reset mid-window
      gate_len = 16'd100;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      repeat (40) @(negedge clk);
      chk("t6_busy_before", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_result", int'(result), 0);
      chk("t6_rst_valid",  int'(valid), 0);
      chk("t6_rst_busy",   int'(busy), 0);
      chk("t6_rst_ovf",    int'(result_ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      run_single(100, n);
      chk("t6_latency", n, 101);
      chk("t6_result",  int'(result), 25);

      // Randomised traffic checked by the per-cycle model comparison
      for (int it = 0; it < 30; it++) begin
         osc_rand = (it % 2) == 1;
         if (!osc_rand) begin
            osc_half = $urandom_range(0, 4);
            osc_hold = 1'($urandom_range(0, 1));
         end
         continuous = 1'($urandom_range(0, 1));
         for (int c = 0; c < 150; c++) begin
            gate_len = 16'($urandom_range(0, 40));
            start    = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 30) == 0);
            @(negedge clk);
         end
      end
      start      = 1'b0;
      abort      = 1'b0;
      continuous = 1'b0;
      osc_rand   = 1'b0;
      repeat (60) @(negedge clk);
      chk("end_idle", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
Parametrised successor to the ring-oscillator edge counter. It measures a free-running oscillator (ring or bypass model) against the system clock. The oscillator is sampled as data through a synchroniser, so the block has only one clock. It counts oscillator rising edges over a programmable gate window of clk cycles and latches a result with a valid pulse. It supports single-shot and continuous modes, abort, and saturating overflow. It sits between the tapped ring and the uo_out/uio_out readout logic.

Parameters:
CNT_W, 15, width of the edge accumulator and the result (matches the existing 15-bit readout).
GATE_W, 16, width of the gate-length input and the internal window counter.
SYNC_STAGES, 2, number of synchroniser flops on osc_in; legal values are 2 or greater.

Ports:
clk  input  1  system clock; all logic is in this domain.
rst_n  input  1  asynchronous, active-low reset.
osc_in  input  1  raw oscillator, asynchronous to clk.
start  input  1  level; sampled in IDLE to begin a measurement.
continuous  input  1  when 1, a new window begins immediately after each completed window.
abort  input  1  terminates the current window with no result.
gate_len  input  GATE_W  window length in clk cycles; sampled at the start of each window.
busy  output  1  1 while a window is in progress.
result  output  CNT_W  edge count from the last completed window.
result_ovf  output  1  1 if the last completed window saturated.
valid  output  1  one-cycle pulse when result and result_ovf update.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert by design integration):
  - sync chain, edge flop, accumulator, window counter = 0.
  - state = IDLE; busy = 0, result = 0, result_ovf = 0, valid = 0.
- Edge detect:
  - osc_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist.
  - Pipeline latency from osc_in to rise = SYNC_STAGES+1 cycles.
  - Maximum measurable frequency is f_clk/2; faster inputs alias, and this is not flagged.
- States: IDLE, MEASURE.
- IDLE:
  - If start=1 and abort=0: load win = max(gate_len,1), clear acc and ovf_acc; next state MEASURE.
  - busy goes 1 on the following cycle.
  - start=1 together with abort=1 in IDLE: no start.
- MEASURE (each cycle):
  - If rise: if acc is all-ones, set ovf_acc and hold acc; else acc = acc+1.
  - win decrements by 1.
  - The window is exactly win cycles long. Rises seen in the first through last MEASURE cycle are counted, including the last cycle.
- Window end (cycle with win==1):
  - result = acc plus that cycle's rise, saturating; result_ovf = ovf_acc, or saturation on that cycle.
  - valid = 1 on the next cycle, for exactly 1 cycle.
  - If continuous=1: reload win = max(gate_len,1), clear acc and ovf_acc, stay in MEASURE. There is no gap cycle; consecutive valids are exactly the window length apart. busy stays 1.
  - Else: next state IDLE, busy = 0 on the cycle valid is asserted.
- abort=1 in MEASURE:
  - Next state IDLE and busy = 0 next cycle.
  - No valid; result and result_ovf are unchanged.
  - abort takes priority over window end on the same cycle.
- start in MEASURE is ignored.
- gate_len and continuous changes mid-window take effect only at the next reload or end.
- The sync chain runs continuously in all states, so no flush is needed between windows.

Test Plan:
- osc_in toggling every 2 clk (period 4, bench-synchronous), gate_len=100, single-shot start: exactly 1 valid at cycle start+101; result=25, result_ovf=0; busy 0 afterwards.
- CNT_W=4, osc period 2 clk, gate_len=64: result=15, result_ovf=1.
- continuous=1, gate_len=40, osc period 8: 3 consecutive valids spaced exactly 40 cycles apart, each with result=5; drop continuous, then the last valid is followed by busy=0.
- gate_len=0 with osc held high: window lasts 1 cycle, result=0, valid pulses once; the same test with gate_len=1 gives an identical trace.
- abort asserted 30 cycles into a 100-cycle window after a previous result=25: no valid, result stays 25, busy=0 next cycle; start+abort together in IDLE leaves busy=0.
- rst_n pulled low mid-window with result=25 held: result, valid, busy and result_ovf go 0 immediately (asynchronously); after release, a fresh start with period 4 and gate_len=100 gives result=25.
